cache_refill_ctrl: RTL and testbench

Miss-handling and refill controller for the direct-mapped data cache. Sits between the cache lookup path (decode, tag array, hit detect) and DataMemory. It serves hits from cache data, fetches missed words from memory via a req/ready/valid handshake, writes the fill into the cache array, and handles index invalidation on flush. Also keeps saturating hit and miss counters.

---
 rtl/cache_refill_ctrl.sv | 143 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: direct-mapped cache miss/refill controller with flush invalidation and hit/miss statistics
module cache_refill_ctrl #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iReq,
    input  logic [31:0]        iAddress,
    input  logic               iHit,
    input  logic [DATA_W-1:0]  iCacheData,
    input  logic               iFlush,
    input  logic [31:0]        iFlushAddress,
    output logic               oBusy,
    output logic               oDataValid,
    output logic [DATA_W-1:0]  oData,
    output logic               oError,
    output logic               oMemReq,
    output logic [31:0]        oMemAddr,
    input  logic               iMemReady,
    input  logic               iMemValid,
    input  logic [DATA_W-1:0]  iMemData,
    output logic               oFillEn,
    output logic [INDEX_W-1:0] oFillIndex,
    output logic [TAG_W-1:0]   oFillTag,
    output logic [DATA_W-1:0]  oFillData,
    output logic               oInvEn,
    output logic [INDEX_W-1:0] oInvIndex,
    output logic [CNT_W-1:0]   oHitCnt,
    output logic [CNT_W-1:0]   oMissCnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, RESP} state_t;

    state_t             r_state;
    logic [TW-1:0]      r_tcnt;
    logic               r_cancel;
    logic [INDEX_W-1:0] r_index;
    logic [TAG_W-1:0]   r_tag;
    logic [DATA_W-1:0]  r_data;
    logic               r_data_valid, r_error, r_mem_req, r_fill_en, r_inv_en;
    logic [31:0]        r_mem_addr;
    logic [INDEX_W-1:0] r_inv_index;
    logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt;

    logic [INDEX_W-1:0] w_req_index, w_flush_index;
    logic               w_conflict, w_flush_hit, w_unused;

    assign w_req_index   = iAddress[INDEX_W+1:2];
    assign w_flush_index = iFlushAddress[INDEX_W+1:2];
    assign w_conflict    = iFlush && (w_flush_index == w_req_index);
    assign w_flush_hit   = iFlush && (w_flush_index == r_index) &&
                           (r_state == REQ || r_state == WAIT || r_state == FILL);
    assign w_unused      = ^{iAddress[1:0], iFlushAddress[31:INDEX_W+2], iFlushAddress[1:0]};

    // One data register serves both the hit response and the refill word; they never overlap.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state      <= IDLE;
            r_tcnt       <= '0;
            r_cancel     <= 1'b0;
            r_index      <= '0;
            r_tag        <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_fill_en    <= 1'b0;
            r_inv_en     <= 1'b0;
            r_inv_index  <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
            r_fill_en    <= 1'b0;
            r_inv_en     <= iFlush;
            if (iFlush) r_inv_index <= w_flush_index;
            if (w_flush_hit) r_cancel <= 1'b1;
            case (r_state)
                IDLE: if (iReq) begin
                    if (iHit && !w_conflict) begin
                        r_data_valid <= 1'b1;
                        r_data       <= iCacheData;
                        r_hit_cnt    <= r_hit_cnt + CNT_W'(r_hit_cnt != '1);
                    end else begin
                        r_index    <= w_req_index;
                        r_tag      <= iAddress[31:INDEX_W+2];
                        r_mem_addr <= {iAddress[31:2], 2'b00};
                        r_mem_req  <= 1'b1;
                        r_miss_cnt <= r_miss_cnt + CNT_W'(r_miss_cnt != '1);
                        r_state    <= REQ;
                    end
                end
                REQ: if (iMemReady) begin
                    r_mem_req <= 1'b0;
                    r_tcnt    <= '0;
                    r_state   <= WAIT;
                end
                WAIT: if (iMemValid) begin
                    r_data    <= iMemData;
                    r_fill_en <= !(r_cancel || w_flush_hit);
                    r_state   <= FILL;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    r_error  <= 1'b1;
                    r_cancel <= 1'b0;
                    r_state  <= IDLE;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
                FILL: begin
                    r_data_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_cancel <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oBusy      = (r_state != IDLE);
    assign oDataValid = r_data_valid;
    assign oData      = r_data;
    assign oError     = r_error;
    assign oMemReq    = r_mem_req;
    assign oMemAddr   = r_mem_addr;
    assign oFillEn    = r_fill_en;
    assign oFillIndex = r_index;
    assign oFillTag   = r_tag;
    assign oFillData  = r_data;
    assign oInvEn     = r_inv_en;
    assign oInvIndex  = r_inv_index;
    assign oHitCnt    = r_hit_cnt;
    assign oMissCnt   = r_miss_cnt;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed stimulus against a transaction-level model, checked every cycle
module tb_cache_refill_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        iReq = 0, iHit = 0, iFlush = 0, iMemReady = 0, iMemValid = 0;
    logic [31:0] iAddress = 0, iCacheData = 0, iFlushAddress = 0, iMemData = 0;
    logic        oBusy, oDataValid, oError, oMemReq, oFillEn, oInvEn;
    logic [31:0] oData, oMemAddr, oFillData;
    logic [3:0]  oFillIndex, oInvIndex;
    logic [25:0] oFillTag;
    logic [15:0] oHitCnt, oMissCnt;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.TIMEOUT(TO)) dut (
        .iClk(clk), .iRst(rst_n), .iReq(iReq), .iAddress(iAddress), .iHit(iHit),
        .iCacheData(iCacheData), .iFlush(iFlush), .iFlushAddress(iFlushAddress),
        .oBusy(oBusy), .oDataValid(oDataValid), .oData(oData), .oError(oError),
        .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemReady(iMemReady),
        .iMemValid(iMemValid), .iMemData(iMemData), .oFillEn(oFillEn),
        .oFillIndex(oFillIndex), .oFillTag(oFillTag), .oFillData(oFillData),
        .oInvEn(oInvEn), .oInvIndex(oInvIndex), .oHitCnt(oHitCnt), .oMissCnt(oMissCnt)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    // Model: one outstanding miss tracked by progress counters, not by a state enum.
    bit        m_busy, m_rdy, m_cancel, fm;
    int        m_waited, m_got;
    bit [3:0]  m_idx;
    bit [31:0] m_addr, m_data;
    bit        e_dv, e_err, e_req, e_fill, e_inv;
    bit [31:0] e_data, e_addr, e_fdata;
    bit [3:0]  e_fidx, e_inv_idx;
    bit [25:0] e_ftag;
    int        e_hit, e_miss;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_rdy = 0; m_cancel = 0; m_waited = 0; m_got = -1;
            m_idx = 0; m_addr = 0; m_data = 0;
            e_dv = 0; e_err = 0; e_req = 0; e_fill = 0; e_inv = 0;
            e_data = 0; e_addr = 0; e_fdata = 0; e_fidx = 0; e_inv_idx = 0; e_ftag = 0;
            e_hit = 0; e_miss = 0;
        end else begin
            fm = iFlush && m_busy && m_got < 1 && iFlushAddress[5:2] == m_idx;
            e_dv = 0; e_err = 0; e_fill = 0; e_inv = iFlush;
            if (iFlush) e_inv_idx = iFlushAddress[5:2];
            if (fm) m_cancel = 1;
            if (!m_busy) begin
                if (iReq) begin
                    if (iHit && !(iFlush && iFlushAddress[5:2] == iAddress[5:2])) begin
                        e_dv = 1; e_data = iCacheData;
                        if (e_hit < 65535) e_hit++;
                    end else begin
                        m_busy = 1; m_rdy = 0; m_waited = 0; m_got = -1;
                        m_idx = iAddress[5:2]; m_addr = iAddress & ~32'h3;
                        e_req = 1; e_addr = m_addr;
                        if (e_miss < 65535) e_miss++;
                    end
                end
            end else if (!m_rdy) begin
                if (iMemReady) begin m_rdy = 1; e_req = 0; end
            end else if (m_got < 0) begin
                m_waited++;
                if (iMemValid) begin
                    m_got = 0; m_data = iMemData;
                    e_fill = !m_cancel; e_fidx = m_idx; e_ftag = m_addr[31:6]; e_fdata = iMemData;
                end else if (m_waited == TO) begin
                    e_err = 1; m_busy = 0; m_cancel = 0;
                end
            end else if (m_got == 0) begin
                m_got = 1; e_dv = 1; e_data = m_data;
            end else begin
                m_busy = 0; m_cancel = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", oBusy, m_busy);
        chk("data_valid", oDataValid, e_dv);
        if (e_dv) chk("data", oData, e_data);
        chk("error", oError, e_err);
        chk("mem_req", oMemReq, e_req);
        if (e_req) chk("mem_addr", oMemAddr, e_addr);
        chk("fill_en", oFillEn, e_fill);
        if (e_fill) begin
            chk("fill_index", oFillIndex, e_fidx);
            chk("fill_tag", oFillTag, e_ftag);
            chk("fill_data", oFillData, e_fdata);
        end
        chk("inv_en", oInvEn, e_inv);
        if (e_inv) chk("inv_index", oInvIndex, e_inv_idx);
        chk("hit_cnt", oHitCnt, e_hit);
        chk("miss_cnt", oMissCnt, e_miss);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [31:0] a);
        iAddress = a; iHit = 0; iReq = 1;
        tick();
        iReq = 0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", oBusy, 0);
        chk("rst_hitcnt", oHitCnt, 0);
        chk("rst_misscnt", oMissCnt, 0);
        chk("rst_dv", oDataValid, 0);
        rst_n = 1;
        tick();
        // hit
        iAddress = 32'h40; iHit = 1; iCacheData = 32'hDEADBEEF; iReq = 1;
        tick();
        iReq = 0; iHit = 0;
        chk("hit_dv", oDataValid, 1);
        chk("hit_data", oData, 32'hDEADBEEF);
        chk("hit_cnt1", oHitCnt, 1);
        chk("hit_busy", oBusy, 0);
        tick();
        // miss refill: ready after 2 cycles, valid after 3
        miss(32'h104);
        chk("miss_req", oMemReq, 1);
        chk("miss_addr", oMemAddr, 32'h104);
        chk("miss_cnt1", oMissCnt, 1);
        tick();
        iMemReady = 1;
        tick();
        iMemReady = 0;
        tick(); tick();
        iMemValid = 1; iMemData = 32'h1234_5678;
        tick();
        iMemValid = 0;
        chk("refill_fill", oFillEn, 1);
        chk("refill_idx", oFillIndex, 4'h1);
        chk("refill_tag", oFillTag, 26'h4);
        chk("refill_data", oFillData, 32'h1234_5678);
        tick();
        chk("refill_dv", oDataValid, 1);
        chk("refill_data_out", oData, 32'h1234_5678);
        tick();
        chk("refill_idle", oBusy, 0);
        // timeout exactly TO cycles after entering WAIT
        miss(32'h208);
        iMemReady = 1;
        tick();
        iMemReady = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("to_early_err", oError, 0);
        end
        tick();
        chk("to_err", oError, 1);
        chk("to_busy", oBusy, 0);
        chk("to_fill", oFillEn, 0);
        chk("to_dv", oDataValid, 0);
        tick();
        chk("to_err_pulse", oError, 0);
        // valid on the final WAIT cycle beats the timeout
        miss(32'h210);
        iMemReady = 1;
        tick();
        iMemReady = 0;
        repeat (TO - 1) tick();
        iMemValid = 1; iMemData = 32'hA5A5_0001;
        tick();
        iMemValid = 0;
        chk("edge_err", oError, 0);
        chk("edge_fill", oFillEn, 1);
        tick(); tick();
        // flush cancel during WAIT
        miss(32'h30C);
        iMemReady = 1;
        tick();
        iMemReady = 0; iFlush = 1; iFlushAddress = 32'h0C;
        tick();
        iFlush = 0;
        chk("fc_inv", oInvEn, 1);
        chk("fc_inv_idx", oInvIndex, 4'h3);
        iMemValid = 1; iMemData = 32'hCAFE_F00D;
        tick();
        iMemValid = 0;
        chk("fc_fill", oFillEn, 0);
        tick();
        chk("fc_dv", oDataValid, 1);
        chk("fc_data", oData, 32'hCAFE_F00D);
        tick();
        // flush and hit request on the same index in IDLE -> miss
        iAddress = 32'h20; iFlushAddress = 32'h20; iHit = 1; iFlush = 1; iReq = 1;
        tick();
        iReq = 0; iFlush = 0; iHit = 0;
        chk("sim_inv", oInvEn, 1);
        chk("sim_inv_idx", oInvIndex, 4'h8);
        chk("sim_req", oMemReq, 1);
        chk("sim_hitcnt", oHitCnt, 1);
        chk("sim_misscnt", oMissCnt, 5);
        iMemReady = 1;
        tick();
        iMemReady = 0; iMemValid = 1; iMemData = 32'h55AA;
        tick();
        iMemValid = 0;
        chk("sim_fill", oFillEn, 1);
        tick(); tick();
        // reset in the middle of a miss
        miss(32'h44);
        iMemReady = 1;
        tick();
        iMemReady = 0;
        rst_n = 0;
        #1;
        chk("mr_busy", oBusy, 0);
        chk("mr_req", oMemReq, 0);
        chk("mr_misscnt", oMissCnt, 0);
        chk("mr_hitcnt", oHitCnt, 0);
        tick();
        rst_n = 1; iMemValid = 1; iMemData = 32'h9999;
        tick();
        iMemValid = 0;
        chk("mr_fill", oFillEn, 0);
        chk("mr_dv", oDataValid, 0);
        chk("mr_idle", oBusy, 0);
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
